// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared word layout, buffer sizing and index helper for the FIFO read-side stream
package fifo_rd_stream_pkg;
  localparam int FIFO_W = 65;
  localparam int LAST_BIT = FIFO_W - 1;
  localparam int BUF_DEPTH = 3;
  typedef struct packed {
    logic last;
    logic [LAST_BIT-1:0] payload;
  } fifo_word_t;
  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    return (i == 2'(BUF_DEPTH - 1)) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_stream_stats.sv
// stream_stats: saturating beat-within-frame and completed-frame counters; ports clk, rst, xfer, last -> beat_cnt, frame_cnt
module stream_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer,
  input  logic             last,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] frame_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (xfer) begin
      beat_cnt  <= last ? '0 : (&beat_cnt ? beat_cnt : beat_cnt + 1'b1);
      frame_cnt <= (last && !(&frame_cnt)) ? frame_cnt + 1'b1 : frame_cnt;
    end
  end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO pop interface to valid/ready stream via 3-entry prefetch buffer; ports clk, rst, fifo_empty, rd_fire, rd_data, m_valid, m_ready, m_data, m_last, beat_cnt, frame_cnt
import fifo_rd_stream_pkg::*;
module fifo_rd_stream #(
  parameter int DATA_W = FIFO_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              rd_fire,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-2:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [1:0] rd_idx, wr_idx, count;
  logic inflight, xfer;
  assign m_valid = count != 2'd0;
  assign xfer = m_valid && m_ready;
  // reserve a slot for the word already popped but not yet captured, so a capture never meets a full buffer
  assign rd_fire = !fifo_empty && !rst && (({1'b0, count} + 3'(inflight)) < 3'(BUF_DEPTH));
  assign {m_last, m_data} = mem[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '{default: '0};
      rd_idx   <= '0;
      wr_idx   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_fire;
      if (inflight) mem[wr_idx] <= rd_data;
      if (inflight) wr_idx <= idx_inc(wr_idx);
      if (xfer) rd_idx <= idx_inc(rd_idx);
      count <= count + 2'(inflight) - 2'(xfer);
    end
  end
  stream_stats #(.CNT_W(CNT_W)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .xfer     (xfer),
    .last     (m_last),
    .beat_cnt (beat_cnt),
    .frame_cnt(frame_cnt)
  );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized self-checking bench with a queue-based reference model of the read-side stream
module tb_fifo_rd_stream;
  localparam int DW = 65;
  logic clk = 1'b0, rst = 1'b1, fifo_empty = 1'b1, m_ready = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic rd_fire, m_valid, m_last, rd_fire4, m_valid4, m_last4;
  logic [DW-2:0] m_data, m_data4;
  logic [15:0] beat_cnt, frame_cnt;
  logic [3:0] beat4, frame4;
  always #5 clk = ~clk;
  fifo_rd_stream dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .rd_fire(rd_fire), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .beat_cnt(beat_cnt), .frame_cnt(frame_cnt)
  );
  fifo_rd_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .rd_fire(rd_fire4), .rd_data(rd_data),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4),
    .beat_cnt(beat4), .frame_cnt(frame4)
  );
  logic [DW-1:0] src[$], mbuf[$], got[$], sent[$];
  logic infl = 1'b0, fire_q = 1'b0, exp_fire_q = 1'b0, xfer_q = 1'b0, rst_q = 1'b1;
  int beat_m = 0, frame_m = 0, beat4_m = 0, frame4_m = 0;
  int n_chk = 0, n_pass = 0, cyc = 0, n_fire = 0, first_fire = -1, first_valid = -1;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask
  task automatic cycle(input logic r, input logic rdy, input logic fl);
    logic [DW-1:0] w;
    logic ef, ev;
    @(negedge clk);
    if (rst_q) begin
      mbuf.delete();
      src.delete();
      infl = 1'b0;
      beat_m = 0; frame_m = 0; beat4_m = 0; frame4_m = 0;
    end else begin
      if (xfer_q) begin
        w = mbuf.pop_front();
        if (w[DW-1]) begin
          beat_m = 0; beat4_m = 0;
          frame_m = (frame_m == 65535) ? frame_m : frame_m + 1;
          frame4_m = (frame4_m == 15) ? frame4_m : frame4_m + 1;
        end else begin
          beat_m = (beat_m == 65535) ? beat_m : beat_m + 1;
          beat4_m = (beat4_m == 15) ? beat4_m : beat4_m + 1;
        end
      end
      if (infl) mbuf.push_back(rd_data);
      infl = exp_fire_q;
      if (fire_q && src.size() != 0) rd_data = src.pop_front();
    end
    rst = r;
    m_ready = rdy;
    fifo_empty = (src.size() == 0) || fl;
    #1;
    ef = !fifo_empty && !rst && (mbuf.size() + int'(infl) < 3);
    ev = mbuf.size() != 0;
    chk("rd_fire", rd_fire, ef);
    chk("rd_fire_w4", rd_fire4, ef);
    chk("m_valid", m_valid, ev);
    chk("m_valid_w4", m_valid4, ev);
    if (ev) begin
      chk("m_word", {m_last, m_data}, mbuf[0]);
      chk("m_word_w4", {m_last4, m_data4}, mbuf[0]);
    end
    chk("beat_cnt", beat_cnt, beat_m);
    chk("frame_cnt", frame_cnt, frame_m);
    chk("beat_cnt_w4", beat4, beat4_m);
    chk("frame_cnt_w4", frame4, frame4_m);
    if (rd_fire) n_fire++;
    if (rd_fire && first_fire < 0) first_fire = cyc;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) got.push_back({m_last, m_data});
    fire_q = rd_fire;
    exp_fire_q = ef;
    xfer_q = ev && rdy && !r;
    rst_q = r;
    cyc++;
  endtask
  task automatic drain(input int lim);
    int i = 0;
    while ((src.size() != 0 || mbuf.size() != 0 || infl) && i < lim) begin
      cycle(1'b0, 1'b1, 1'b0);
      i++;
    end
    chk("drain_timeout", i < lim, 1'b1);
  endtask
  initial begin
    int i, vcnt, lim;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rd_fire", rd_fire, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_frame", frame_cnt, 0);
    n_fire = 0; first_fire = -1; first_valid = -1; got.delete();
    for (int k = 1; k <= 4; k++) src.push_back({1'(k == 4), 64'(k)});
    drain(50);
    chk("t1_pops", n_fire, 4);
    chk("t1_first_latency", first_valid - first_fire, 2);
    chk("t1_words", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("t1_word", got[k], {1'(k == 3), 64'(k + 1)});
    chk("t1_frame", frame_cnt, 1);
    chk("t1_beat", beat_cnt, 0);
    n_fire = 0; got.delete();
    for (int k = 0; k < 10; k++) src.push_back({1'b0, 64'(64'h100 + k)});
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    chk("t2_pops", n_fire, 3);
    chk("t2_hold_data", m_data, 64'h100);
    chk("t2_hold_valid", m_valid, 1);
    drain(100);
    chk("t2_words", got.size(), 10);
    for (int k = 0; k < 10 && k < got.size(); k++) chk("t2_order", got[k], {1'b0, 64'(64'h100 + k)});
    for (int k = 0; k < 10; k++) src.push_back({1'b0, 64'(64'h300 + k)});
    i = 0;
    while (!(mbuf.size() == 2 && infl) && i < 20) begin
      cycle(1'b0, 1'b0, 1'b0);
      i++;
    end
    chk("t4_setup", i < 20, 1'b1);
    got.delete();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t4_m_valid", m_valid, 0);
    chk("t4_rd_fire", rd_fire, 0);
    chk("t4_beat", beat_cnt, 0);
    chk("t4_frame", frame_cnt, 0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0);
    chk("t4_no_output", got.size(), 0);
    for (int k = 0; k < 20; k++) src.push_back({1'b1, 64'(64'h400 + k)});
    drain(200);
    chk("t5_frame_sat", frame4, 15);
    chk("t5_frame_wide", frame_cnt, 20);
    for (int k = 0; k < 19; k++) src.push_back({1'b0, 64'(64'h500 + k)});
    drain(200);
    chk("t5_beat_sat", beat4, 15);
    chk("t5_beat_wide", beat_cnt, 19);
    src.push_back({1'b1, 64'h5ff});
    drain(50);
    chk("t5_beat_clr", beat4, 0);
    chk("t5_beat_clr_wide", beat_cnt, 0);
    chk("t5_frame_hold", frame4, 15);
    chk("t5_frame_wide2", frame_cnt, 21);
    got.delete();
    for (int k = 0; k < 110; k++) src.push_back({1'b0, 64'(64'h1000 + k)});
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    vcnt = 0;
    repeat (100) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (m_valid) vcnt++;
    end
    chk("t6_valid_cycles", vcnt, 100);
    chk("t6_beats", got.size(), 101);
    drain(200);
    got.delete(); sent.delete();
    lim = 0;
    while ((sent.size() < 1000 || src.size() != 0 || mbuf.size() != 0 || infl) && lim < 20000) begin
      if (sent.size() < 1000 && $urandom_range(0, 9) < 6) begin
        sent.push_back({1'($urandom_range(0, 7) == 0), $urandom, $urandom});
        src.push_back(sent[$]);
      end
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      lim++;
    end
    chk("t3_timeout", lim < 20000, 1'b1);
    chk("t3_count", got.size(), 1000);
    vcnt = 0;
    for (int k = 0; k < 1000 && k < got.size(); k++) if (got[k] === sent[k]) vcnt++;
    chk("t3_order", vcnt, 1000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
